// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Arbitrates write requests from two requesters onto the single write port of
// a data memory. Requester A is the CPU store path and requester B is the
// program/debug loader. Contention is resolved round-robin. A requester whose
// ack is high in the current cycle is masked, so a held request is not written
// twice.
//
// Optional feature: define DMEM_CLEAR_EN to build in the clear sequencer.
// The sequencer writes zero to every address after each reset release, and
// again whenever clear_req is seen in IDLE. Without the macro, clear_req is
// ignored and busy is tied low.
//
// Parameters
//   ADDR_W        data-memory address width (default 4, 16 locations)
//   DATA_W        data-memory word width (default 8)
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   req_a/req_b   write requests; each is held with its addr/data until acked
//   addr_a/addr_b target addresses
//   wdata_a/b     write data
//   ack_a/ack_b   one-cycle pulse, registered: that requester's write issued
//   clear_req     request a full memory clear
//   busy          high while a clear is writing (registered)
//   mem_load      memory write strobe (registered)
//   mem_addr      memory write address (registered)
//   mem_wdata     memory write data (registered)
//   mem_is_instr  constant 0: every write targets data memory
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_a,
  output logic              ack_b,
  input  logic              clear_req,
  output logic              busy,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_is_instr
);

  // 1 = B was granted most recently, so A wins the next contention.
  logic last_b_reg;

  logic elig_a;
  logic elig_b;
  logic grant_a;
  logic grant_b;

  // A requester whose ack is high this cycle was just written. Its req is
  // still high only because it has not yet seen the ack, so it is masked.
  always_comb begin
    elig_a  = req_a && !ack_a;
    elig_b  = req_b && !ack_b;
    grant_a = elig_a && (!elig_b || last_b_reg);
    grant_b = elig_b && !grant_a;
  end

  assign mem_is_instr = 1'b0;

`ifdef DMEM_CLEAR_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              busy_reg;

  assign busy = busy_reg;
`else
  // The clear request has no function in this build.
  logic unused_clear_req;
  assign unused_clear_req = clear_req;
  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_load    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      last_b_reg  <= 1'b1;
`ifdef DMEM_CLEAR_EN
      // Parking in CLEAR with busy low makes the first edge after release
      // issue the address-0 clear write.
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
      busy_reg    <= 1'b0;
`endif
    end
`ifdef DMEM_CLEAR_EN
    // A clear_req seen in IDLE issues its first write on the same edge that
    // enters CLEAR. This gives the reset path and the request path the same
    // timing, and a clear_req beats any pending request. Once in CLEAR,
    // clear_req has no effect.
    else if (state_reg == CLEAR || clear_req) begin
      mem_load    <= 1'b1;
      mem_addr    <= clr_cnt_reg;
      mem_wdata   <= '0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      busy_reg    <= 1'b1;
      clr_cnt_reg <= clr_cnt_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
      state_reg   <= (clr_cnt_reg == {ADDR_W{1'b1}}) ? IDLE : CLEAR;
    end
`endif
    else begin
`ifdef DMEM_CLEAR_EN
      busy_reg <= 1'b0;
`endif
      mem_load <= grant_a || grant_b;
      ack_a    <= grant_a;
      ack_b    <= grant_b;
      // With no grant, address and data keep their last values.
      if (grant_a) begin
        mem_addr   <= addr_a;
        mem_wdata  <= wdata_a;
        last_b_reg <= 1'b0;
      end else if (grant_b) begin
        mem_addr   <= addr_b;
        mem_wdata  <= wdata_b;
        last_b_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Self-checking bench for data_mem_arbiter. Works in both the default build
// and the DMEM_CLEAR_EN build. The bench pushes an expected output record onto
// a scoreboard queue each time it drives a cycle of stimulus. It pops and
// compares that record #1 after the clock edge that produces the result.
// Arbitration vectors come from a table; clear and reset corner cases are
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_a;
  logic [3:0] addr_a;
  logic [7:0] wdata_a;
  logic       req_b;
  logic [3:0] addr_b;
  logic [7:0] wdata_b;
  logic       ack_a;
  logic       ack_b;
  logic       clear_req;
  logic       busy;
  logic       mem_load;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_is_instr;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       load;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       ack_a;
    logic       ack_b;
    logic       busy;
  } exp_t;

  typedef struct {
    logic       ra;
    logic [3:0] aa;
    logic [7:0] da;
    logic       rb;
    logic [3:0] ab;
    logic [7:0] db;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  data_mem_arbiter #(
    .ADDR_W(4),
    .DATA_W(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_a        (req_a),
    .addr_a       (addr_a),
    .wdata_a      (wdata_a),
    .req_b        (req_b),
    .addr_b       (addr_b),
    .wdata_b      (wdata_b),
    .ack_a        (ack_a),
    .ack_b        (ack_b),
    .clear_req    (clear_req),
    .busy         (busy),
    .mem_load     (mem_load),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_is_instr (mem_is_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The two acks must never be high together.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (ack_a && ack_b)
        $display("FAIL both_acks: ack_a=%0b ack_b=%0b, required not both 1", ack_a, ack_b);
      else
        n_pass++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk_exp(logic l, logic [3:0] a, logic [7:0] d,
                                  logic aa, logic ab, logic b);
    exp_t e;
    e.load  = l;
    e.addr  = a;
    e.wdata = d;
    e.ack_a = aa;
    e.ack_b = ab;
    e.busy  = b;
    return e;
  endfunction

  function automatic vec_t mk_vec(logic ra, logic [3:0] aa, logic [7:0] da,
                                  logic rb, logic [3:0] ab, logic [7:0] db,
                                  exp_t e);
    vec_t v;
    v.ra = ra;
    v.aa = aa;
    v.da = da;
    v.rb = rb;
    v.ab = ab;
    v.db = db;
    v.e  = e;
    return v;
  endfunction

  task automatic push_exp(input logic l, input logic [3:0] a, input logic [7:0] d,
                          input logic aa, input logic ab, input logic b);
    sb_q.push_back(mk_exp(l, a, d, aa, ab, b));
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, no expected record", name);
      return;
    end
    e = sb_q.pop_front();
    if (mem_load !== e.load || mem_addr !== e.addr || mem_wdata !== e.wdata ||
        ack_a !== e.ack_a || ack_b !== e.ack_b || busy !== e.busy || mem_is_instr !== 1'b0)
      $display("FAIL %s: got load=%0b addr=%h wdata=%h ack_a=%0b ack_b=%0b busy=%0b instr=%0b, required load=%0b addr=%h wdata=%h ack_a=%0b ack_b=%0b busy=%0b instr=0",
               name, mem_load, mem_addr, mem_wdata, ack_a, ack_b, busy, mem_is_instr,
               e.load, e.addr, e.wdata, e.ack_a, e.ack_b, e.busy);
    else begin
      n_pass++;
      $display("ok   %s: load=%0b addr=%h wdata=%h ack_a=%0b ack_b=%0b busy=%0b",
               name, mem_load, mem_addr, mem_wdata, ack_a, ack_b, busy);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    #1;
    sb_check(name);
  endtask

  initial begin
    // Stimulus table: inputs for one cycle, then the outputs expected after that edge.
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 1, 4'h1, 8'h11, mk_exp(1, 4'h1, 8'h11, 0, 1, 0)));
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, mk_exp(0, 4'h1, 8'h11, 0, 0, 0)));
    vecs.push_back(mk_vec(1, 4'h3, 8'h5A, 0, 4'h0, 8'h00, mk_exp(1, 4'h3, 8'h5A, 1, 0, 0)));
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, mk_exp(0, 4'h3, 8'h5A, 0, 0, 0)));
    // Contention with A granted last: B wins, then A.
    vecs.push_back(mk_vec(1, 4'h2, 8'h22, 1, 4'h9, 8'h99, mk_exp(1, 4'h9, 8'h99, 0, 1, 0)));
    vecs.push_back(mk_vec(1, 4'h2, 8'h22, 0, 4'h0, 8'h00, mk_exp(1, 4'h2, 8'h22, 1, 0, 0)));
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, mk_exp(0, 4'h2, 8'h22, 0, 0, 0)));
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 1, 4'h5, 8'h55, mk_exp(1, 4'h5, 8'h55, 0, 1, 0)));
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, mk_exp(0, 4'h5, 8'h55, 0, 0, 0)));
    // Both held for 6 cycles with B granted last: A,B,A,B,A,B.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        vecs.push_back(mk_vec(1, 4'h4, 8'h44, 1, 4'hC, 8'hCC, mk_exp(1, 4'h4, 8'h44, 1, 0, 0)));
      else
        vecs.push_back(mk_vec(1, 4'h4, 8'h44, 1, 4'hC, 8'hCC, mk_exp(1, 4'hC, 8'hCC, 0, 1, 0)));
    end
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, mk_exp(0, 4'hC, 8'hCC, 0, 0, 0)));
    // B alone and held: a write every other cycle.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        vecs.push_back(mk_vec(0, 4'h0, 8'h00, 1, 4'h7, 8'h77, mk_exp(1, 4'h7, 8'h77, 0, 1, 0)));
      else
        vecs.push_back(mk_vec(0, 4'h0, 8'h00, 1, 4'h7, 8'h77, mk_exp(0, 4'h7, 8'h77, 0, 0, 0)));
    end
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, mk_exp(0, 4'h7, 8'h77, 0, 0, 0)));
    // A alone and held: masked in the cycle after its ack.
    vecs.push_back(mk_vec(1, 4'h8, 8'h80, 0, 4'h0, 8'h00, mk_exp(1, 4'h8, 8'h80, 1, 0, 0)));
    vecs.push_back(mk_vec(1, 4'h8, 8'h80, 0, 4'h0, 8'h00, mk_exp(0, 4'h8, 8'h80, 0, 0, 0)));
    vecs.push_back(mk_vec(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, mk_exp(0, 4'h8, 8'h80, 0, 0, 0)));

    // Apply reset. rst_n starts high so that the negedge triggers the async reset.
    rst_n     = 1'b1;
    clear_req = 1'b0;
    req_a     = 1'b0;
    addr_a    = 4'h0;
    wdata_a   = 8'h00;
    req_b     = 1'b0;
    addr_b    = 4'h0;
    wdata_b   = 8'h00;
    #2;
    rst_n = 1'b0;
`ifdef DMEM_CLEAR_EN
    req_a   = 1'b1;
    addr_a  = 4'h3;
    wdata_a = 8'h5A;
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    push_exp(0, 4'h0, 8'h00, 0, 0, 0);
    sb_check("reset_state");
    rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
    // Clear after reset release while A waits. A is acked after the clear.
    for (int i = 0; i < 16; i++) begin
      push_exp(1, i[3:0], 8'h00, 0, 0, 1);
      step($sformatf("post_reset_clear_%0d", i));
    end
    push_exp(1, 4'h3, 8'h5A, 1, 0, 0);
    step("ack_a_after_clear");
    req_a = 1'b0;
    push_exp(0, 4'h3, 8'h5A, 0, 0, 0);
    step("idle_after_clear");
`endif

    foreach (vecs[i]) begin
      req_a   = vecs[i].ra;
      addr_a  = vecs[i].aa;
      wdata_a = vecs[i].da;
      req_b   = vecs[i].rb;
      addr_b  = vecs[i].ab;
      wdata_b = vecs[i].db;
      sb_q.push_back(vecs[i].e);
      step($sformatf("vec%0d", i));
    end

`ifdef DMEM_CLEAR_EN
    // clear_req wins over a pending A request.
    clear_req = 1'b1;
    req_a     = 1'b1;
    addr_a    = 4'h6;
    wdata_a   = 8'h66;
    push_exp(1, 4'h0, 8'h00, 0, 0, 1);
    step("clear_req_entry");
    clear_req = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      push_exp(1, i[3:0], 8'h00, 0, 0, 1);
      step($sformatf("clear_%0d", i));
    end
    // Reset in the middle of the clear: outputs go to zero without a clock edge.
    rst_n = 1'b0;
    #1;
    push_exp(0, 4'h0, 8'h00, 0, 0, 0);
    sb_check("reset_mid_clear");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // The clear restarts at 0. A clear_req during the clear must be ignored.
    for (int i = 0; i < 16; i++) begin
      clear_req = (i == 5);
      push_exp(1, i[3:0], 8'h00, 0, 0, 1);
      step($sformatf("restart_clear_%0d", i));
    end
    clear_req = 1'b0;
    push_exp(1, 4'h6, 8'h66, 1, 0, 0);
    step("ack_a_after_restart");
    req_a = 1'b0;
    push_exp(0, 4'h6, 8'h66, 0, 0, 0);
    step("idle_after_restart");
`else
    // With no clear sequencer, clear_req is ignored and B is acked as usual.
    clear_req = 1'b1;
    req_b     = 1'b1;
    addr_b    = 4'hE;
    wdata_b   = 8'hEE;
    push_exp(1, 4'hE, 8'hEE, 0, 1, 0);
    step("clear_req_ignored");
    clear_req = 1'b0;
    req_b     = 1'b0;
    push_exp(0, 4'hE, 8'hEE, 0, 0, 0);
    step("idle_after_clear_req");
`endif

    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL sb_drain: %0d records left, required 0", sb_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
